req_arbiter_8: RTL and testbench
================================

Name: req_arbiter_8

Overview:
- Shares one resource among 8 requesters; a registered grant FSM with hold and timeout, built around priority selection.
- Default policy is fixed priority: req[7] highest, req[0] lowest, matching the team's 8-to-3 priority encoder convention.
- Outputs a one-hot grant, the encoded owner index and a valid flag. Downstream muxes use gnt_id directly as the select.

Parameters:
- MAX_HOLD, 15, maximum consecutive BUSY cycles per grant before forced release; 0 disables the timeout.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines; bit i = requester i, level-sensitive.
- done  input  1  current owner finished; sampled only in BUSY.
- gnt  output  8  one-hot grant, registered; all-zero when no owner.
- gnt_id  output  3  binary index of the owner, registered; 0 when gnt_valid=0.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold counter.

Behaviour:
- Reset (rst=1, async, no clock needed): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0, RR pointer=0.
- States: IDLE, BUSY.
- IDLE with req==0: remain in IDLE; outputs stay 0.
- IDLE with req!=0: select the winner per policy. At the next edge, go to BUSY with gnt=1<<w, gnt_id=w, gnt_valid=1, counter=0. Latency is 1 cycle from req sampled to grant visible.
- BUSY: the grant is held; there is no preemption, and higher-priority requests wait. The counter increments every BUSY cycle.
- BUSY release conditions, evaluated each edge:
  - (a) done=1;
  - (b) req[gnt_id]=0, i.e. the owner dropped its request;
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD-1.
- On release: next state is IDLE, with gnt=0, gnt_id=0, gnt_valid=0. This guarantees one dead cycle between owners, and the next grant appears at the earliest one cycle after that.
- timeout=1 for exactly the IDLE cycle following a release caused only by (c). If (a) or (b) coincides with (c), timeout stays 0.
- done in IDLE is ignored. done and new requests in the same cycle: release first, then arbitrate from IDLE.
- A requester may re-win immediately after a timeout; fairness is only provided by the optional feature.
- Owner index width: gnt_id is always the binary encoding of the single set gnt bit. gnt is never multi-hot.
- Reset asserted mid-grant: gnt drops to 0 asynchronously; the aborted grant produces no timeout pulse.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined: a registered pointer last_id updates to gnt_id on every grant. The search starts at (last_id-1) mod 8 and descends with wrap 0→7, so the last owner becomes lowest priority. With pointer=0 after reset, the first search starts at 7, identical to fixed priority.
- Undefined: pure fixed priority (highest set index wins); no pointer register is synthesized.

Test Plan:
1. Reset: rst=1 with req=8'hFF → gnt=0, gnt_id=0, gnt_valid=0, timeout=0, all without any clk edge.
2. Basic grant:
   - req=8'b00101000 → next cycle gnt=8'b00100000, gnt_id=5, gnt_valid=1.
   - Pulse done=1 for one cycle → next cycle gnt=0.
   - With req=8'b00001000 → following cycle gnt_id=3.
3. No preemption: owner id 1 (req=8'b00000010) holding; raise req=8'b11000010 → gnt stays 8'b00000010 until done. Then one idle cycle, then gnt_id=7.
4. Timeout: MAX_HOLD=4, req=8'b00010000 held, done=0 → gnt_valid high 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt_id=4 re-granted. Repeat with done=1 on the 4th cycle → timeout stays 0.
5. Owner drop and mid-grant reset:
   - Owner id 6 deasserts req[6] → release next edge, timeout=0.
   - Assert rst mid-BUSY → gnt=0 immediately; after rst=0, re-arbitration from IDLE.
6. Policy, req=8'b10000001 held, done pulsed each grant:
   - Without ROUND_ROBIN_EN → gnt_id sequence 7,7,7,7.
   - With ROUND_ROBIN_EN → 7,0,7,0.

Source files
------------

// File: rtl/req_arbiter_8.sv
// -----------------------------------------------------------------------------
// req_arbiter_8
//
// Purpose:
//   Shares one resource among 8 requesters. A two-state grant FSM (IDLE/BUSY)
//   registers the grant, holds it until the owner signals done, drops its
//   request, or the hold counter expires. No preemption: higher-priority
//   requests wait until the current owner is released. Each release is
//   followed by one dead cycle before the next owner is granted.
//
//   Default policy is fixed priority: req[7] is highest, req[0] is lowest.
//   Defining the macro ROUND_ROBIN_EN adds a last-owner pointer. Arbitration
//   then starts searching one index below the last owner and descends with
//   wrap-around, so the most recent owner has the lowest priority.
//
// Parameters:
//   MAX_HOLD  maximum consecutive BUSY cycles per grant (0 = no timeout)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   req[7:0]   in   level-sensitive request lines
//   done       in   current owner finished (only looked at in BUSY)
//   gnt[7:0]   out  registered one-hot grant, zero when there is no owner
//   gnt_id     out  registered binary owner index, zero when not valid
//   gnt_valid  out  high while a grant is held
//   timeout    out  one-cycle pulse after a grant is revoked by the counter
// -----------------------------------------------------------------------------
module req_arbiter_8 #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter value in the last BUSY cycle a grant is allowed to last.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam bit               HOLD_EN   = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       win_id;

`ifdef ROUND_ROBIN_EN
    logic [2:0]       last_id_q, last_id_d;
    logic [2:0]       search_start;
    logic [2:0]       cand;
    logic             found;

    // Descend from one below the last owner, wrapping 0 -> 7; the first
    // asserted request wins. After reset last_id is 0, so the search starts
    // at 7, which matches fixed priority.
    always_comb begin
        win_id       = '0;
        found        = 1'b0;
        cand         = '0;
        search_start = last_id_q - 3'd1;
        for (int k = 0; k < 8; k++) begin
            cand = search_start - 3'(k);
            if (!found && req[cand]) begin
                win_id = cand;
                found  = 1'b1;
            end
        end
    end
`else
    // Fixed priority: the loop ascends, so the highest set index wins.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                win_id = 3'(i);
            end
        end
    end
`endif

    // Next-state logic. A release always lands in IDLE with every grant
    // output cleared, so arbitration only happens from IDLE. That produces
    // the dead cycle between owners, and any done or request seen in the
    // same cycle as the release is handled as "release first, then arbitrate".
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
`ifdef ROUND_ROBIN_EN
        last_id_d   = last_id_q;
`endif
        unique case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
                if (|req) begin
                    state_d     = BUSY;
                    gnt_d       = 8'b0000_0001 << win_id;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
`ifdef ROUND_ROBIN_EN
                    last_id_d   = win_id;
`endif
                end
            end
            BUSY: begin
                if (done || !req[gnt_id_q] || (HOLD_EN && (cnt_q == HOLD_LAST))) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    // Flag a timeout only when the counter alone forced the release.
                    timeout_d   = !done && req[gnt_id_q];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously,
    // so an aborted grant vanishes without a timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
`ifdef ROUND_ROBIN_EN
            last_id_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
`ifdef ROUND_ROBIN_EN
            last_id_q   <= last_id_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter_8.sv
// -----------------------------------------------------------------------------
// tb_req_arbiter_8
//
// Directed bench for req_arbiter_8 built with MAX_HOLD=4 so that timeouts
// happen quickly. Expected values are worked out by hand for each step.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_req_arbiter_8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int vectors;
   int miscompares;

   req_arbiter_8 #(
      .MAX_HOLD(4),
      .CNT_W   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .done     (done),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .gnt_valid(gnt_valid),
      .timeout  (timeout)
   );

   // 10-unit clock period, first rising edge at t=5
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive the request lines and done together
   task automatic applyStimulus(input logic [7:0] reqVal, input logic doneVal);
      req  = reqVal;
      done = doneVal;
   endtask

   // Advance one rising edge and step away from it before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare every output against its hand-computed value
   task automatic checkOutput(input string tag, input logic [7:0] expGnt,
                              input logic [2:0] expId, input logic expValid,
                              input logic expTimeout);
      vectors++;
      assert (gnt === expGnt) else begin
         miscompares++;
         $error("[TB] FAIL %s gnt: observed %b expected %b", tag, gnt, expGnt);
      end
      vectors++;
      assert (gnt_id === expId) else begin
         miscompares++;
         $error("[TB] FAIL %s gnt_id: observed %0d expected %0d", tag, gnt_id, expId);
      end
      vectors++;
      assert (gnt_valid === expValid) else begin
         miscompares++;
         $error("[TB] FAIL %s gnt_valid: observed %b expected %b", tag, gnt_valid, expValid);
      end
      vectors++;
      assert (timeout === expTimeout) else begin
         miscompares++;
         $error("[TB] FAIL %s timeout: observed %b expected %b", tag, timeout, expTimeout);
      end
   endtask

   // Linear directed sequence covering the whole test plan
   initial begin
      logic [2:0] policyIds [4];
`ifdef ROUND_ROBIN_EN
      policyIds = '{3'd7, 3'd0, 3'd7, 3'd0};
`else
      policyIds = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
      vectors     = 0;
      miscompares = 0;

      // Reset takes effect without any clock edge
      rst = 1'b0;
      applyStimulus(8'hFF, 1'b0);
      #1 rst = 1'b1;
      #1 checkOutput("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      checkOutput("idle_no_req", 8'h00, 3'd0, 1'b0, 1'b0);

      // Basic grant, done release, next grant after one dead cycle
      $display("[TB] basic grant");
      applyStimulus(8'b0010_1000, 1'b0);
      tick();
      checkOutput("grant_5", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
      applyStimulus(8'b0010_1000, 1'b1);
      tick();
      checkOutput("done_release", 8'h00, 3'd0, 1'b0, 1'b0);
      applyStimulus(8'b0000_1000, 1'b0);
      tick();
      checkOutput("grant_3", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
      applyStimulus(8'b0000_1000, 1'b1);
      tick();
      checkOutput("release_3", 8'h00, 3'd0, 1'b0, 1'b0);

      // No preemption by higher-priority requesters
      $display("[TB] no preemption");
      applyStimulus(8'b0000_0010, 1'b0);
      tick();
      checkOutput("grant_1", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
      applyStimulus(8'b1100_0010, 1'b0);
      tick();
      checkOutput("hold_1_a", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
      tick();
      checkOutput("hold_1_b", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
      applyStimulus(8'b1100_0010, 1'b1);
      tick();
      checkOutput("release_1", 8'h00, 3'd0, 1'b0, 1'b0);
      applyStimulus(8'b1100_0010, 1'b0);
      tick();
      checkOutput("grant_7", 8'b1000_0000, 3'd7, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0);
      tick();
      checkOutput("drop_7", 8'h00, 3'd0, 1'b0, 1'b0);

      // Timeout after 4 BUSY cycles, then immediate re-grant
      $display("[TB] timeout");
      applyStimulus(8'b0001_0000, 1'b0);
      tick();
      checkOutput("to_grant_c0", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
      tick();
      checkOutput("to_grant_c1", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
      tick();
      checkOutput("to_grant_c2", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
      tick();
      checkOutput("to_grant_c3", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
      tick();
      checkOutput("to_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
      tick();
      checkOutput("to_regrant", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("to2_c3", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
      applyStimulus(8'b0001_0000, 1'b1);
      tick();
      checkOutput("to2_done_wins", 8'h00, 3'd0, 1'b0, 1'b0);

      // Owner drops its request; then a reset mid-grant
      $display("[TB] owner drop and mid-grant reset");
      applyStimulus(8'b0100_0000, 1'b0);
      tick();
      checkOutput("grant_6", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
      applyStimulus(8'b0000_0001, 1'b0);
      tick();
      checkOutput("drop_6", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      checkOutput("grant_0", 8'b0000_0001, 3'd0, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 checkOutput("reset_mid_busy", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      checkOutput("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      checkOutput("post_reset_grant", 8'b0000_0001, 3'd0, 1'b1, 1'b0);

      // Policy: req[7] and req[0] both held, done pulsed on every grant
      $display("[TB] policy sequence");
      applyStimulus(8'b1000_0001, 1'b1);
      tick();
      checkOutput("policy_release_0", 8'h00, 3'd0, 1'b0, 1'b0);
      for (int n = 0; n < 4; n++) begin
         applyStimulus(8'b1000_0001, 1'b0);
         tick();
         checkOutput($sformatf("policy_grant_%0d", n), 8'b0000_0001 << policyIds[n],
                     policyIds[n], 1'b1, 1'b0);
         applyStimulus(8'b1000_0001, 1'b1);
         tick();
         checkOutput($sformatf("policy_release_%0d", n + 1), 8'h00, 3'd0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
